// File: rtl/fifo_rd_fwft.sv
// FWFT adapter: 1-cycle-latency FIFO read port -> valid/ready stream via 2-entry skid buffer.
// Accepted read reaches m_valid 2 edges later; reads stop once buffer plus in-flight word fill 2 slots.
module fifo_rd_fwft #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occ
);

  logic                  rd_pending;
  logic                  pop;
  logic [2:0]            used;
  logic [2:0]            avail;
  logic [2:0]            credit;
  logic [1:0]            occ_nxt;
  logic [DATA_WIDTH-1:0] e0;
  logic [DATA_WIDTH-1:0] e1;
  logic [DATA_WIDTH-1:0] e0_nxt;
  logic [DATA_WIDTH-1:0] e1_nxt;

  // Credit saturates at zero rather than wrapping if the slots are ever over-committed.
  always_comb begin
    pop    = m_valid & m_ready;
    used   = {1'b0, occ} + {2'b00, rd_pending};
    avail  = 3'd2 + {2'b00, pop};
    credit = (used >= avail) ? 3'd0 : (avail - used);
    r_en   = ~empty & (credit != 3'd0) & ~rrst;
  end

  always_comb begin
    occ_nxt = occ;
    e0_nxt  = e0;
    e1_nxt  = e1;
    case ({rd_pending, pop})
      2'b10: begin
        case (occ)
          2'd0: begin
            e0_nxt  = rdata;
            occ_nxt = 2'd1;
          end
          2'd1: begin
            e1_nxt  = rdata;
            occ_nxt = 2'd2;
          end
          default: ;
        endcase
      end
      2'b01: begin
        e0_nxt  = e1;
        occ_nxt = occ - 2'd1;
      end
      2'b11: begin
        if (occ == 2'd1) begin
          e0_nxt = rdata;
        end else if (occ == 2'd2) begin
          e0_nxt = e1;
          e1_nxt = rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ        <= 2'd0;
      rd_pending <= 1'b0;
      e0         <= '0;
      e1         <= '0;
      m_valid    <= 1'b0;
    end else begin
      occ        <= occ_nxt;
      rd_pending <= r_en;
      e0         <= e0_nxt;
      e1         <= e1_nxt;
      m_valid    <= (occ_nxt != 2'd0);
    end
  end

  assign m_data = e0;

endmodule
